// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types.
//
// Contents
//   WORD_W            instruction / data word width
//   ICACHE_TAG_MAX_W  widest icache tag (SETS = 2 leaves 29 tag bits)
//   icache_state_t    icache controller states {IDLE, FETCH}
//   icache_frame_t    one icache frame {valid, tag, data}
//   sat_inc32         saturating 32-bit increment for statistics counters
package cpu_types_pkg;

  localparam int WORD_W           = 32;
  localparam int ICACHE_TAG_MAX_W = 29;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  // The tag field is sized for the smallest legal cache. A cache with
  // more sets stores its narrower tag zero-extended into this field.
  typedef struct packed {
    logic                        valid;
    logic [ICACHE_TAG_MAX_W-1:0] tag;
    logic [WORD_W-1:0]           data;
  } icache_frame_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/icache_frames.sv
// icache_frames: frame storage for the direct-mapped instruction cache.
//
// Ports
//   CLK     in   clock, rising edge
//   nRST    in   asynchronous active-low reset (clears valid bits only)
//   wen     in   fill write enable
//   windex  in   fill frame index
//   wtag    in   fill tag
//   wdata   in   fill instruction word
//   flush   in   clear every valid bit at the next edge (beats wen)
//   rindex  in   lookup frame index
//   rframe  out  frame selected by rindex (combinational read)
module icache_frames
  import cpu_types_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int IIDX_W = $clog2(SETS),
  parameter int TAG_W  = 30 - IIDX_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              wen,
  input  logic [IIDX_W-1:0] windex,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [31:0]       wdata,
  input  logic              flush,
  input  logic [IIDX_W-1:0] rindex,
  output icache_frame_t     rframe
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];

  // Valid bits are the only reset state. A flush in the same cycle as a
  // fill leaves the just-filled frame invalid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (wen) begin
      valid[windex] <= 1'b1;
    end
  end

  // Tag and data are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (wen) begin
      tags[windex] <= wtag;
      data[windex] <= wdata;
    end
  end

  always_comb begin
    rframe       = '0;
    rframe.valid = valid[rindex];
    rframe.tag   = ICACHE_TAG_MAX_W'(tags[rindex]);
    rframe.data  = data[rindex];
  end

endmodule

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache.
//
// Hits return the word in the same cycle. A miss performs a single-word
// fill through memory_control (iREN/iaddr/iwait/iload) and the request is
// then served from the filled frame.
//
// Parameters
//   SETS              number of frames, power of two, >= 2
// Build option
//   ICACHE_STATS_EN   when defined, hitcount/misscount are saturating
//                     counters; otherwise both are tied to 0
//
// Ports
//   CLK, nRST   clock (rising edge), asynchronous active-low reset
//   imemREN     fetch request          imemaddr  fetch byte address
//   iflush      invalidate all frames
//   ihit        imemload valid         imemload  instruction word
//   iREN        fill request           iaddr     fill word address
//   iwait       fill pending           iload     fill data
//   hitcount    hit statistics         misscount miss statistics
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hitcount,
  output logic [31:0] misscount
);

  localparam int IIDX_W = $clog2(SETS);
  localparam int TAG_W  = 30 - IIDX_W;

  icache_state_t     state, next_state;
  logic [29:0]       fill_addr;
  logic [IIDX_W-1:0] req_index;
  logic [TAG_W-1:0]  req_tag;
  icache_frame_t     frame;
  logic              fill_we;
  logic              miss_start;
  logic              unused_offset;

  assign req_index     = imemaddr[IIDX_W+1:2];
  assign req_tag       = imemaddr[31:IIDX_W+2];
  assign unused_offset = ^imemaddr[1:0];

  icache_frames #(
    .SETS   (SETS),
    .IIDX_W (IIDX_W),
    .TAG_W  (TAG_W)
  ) u_frames (
    .CLK    (CLK),
    .nRST   (nRST),
    .wen    (fill_we),
    .windex (fill_addr[IIDX_W-1:0]),
    .wtag   (fill_addr[29:IIDX_W]),
    .wdata  (iload),
    .flush  (iflush),
    .rindex (req_index),
    .rframe (frame)
  );

  // Lookups only happen in IDLE; a pending flush masks every hit because
  // the frames are about to be invalidated.
  always_comb begin
    ihit = (state == IDLE) && imemREN && frame.valid && !iflush &&
           (frame.tag == ICACHE_TAG_MAX_W'(req_tag));
    imemload = ihit ? frame.data : 32'h0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      fill_addr <= '0;
    end else begin
      state <= next_state;
      if (miss_start) begin
        fill_addr <= imemaddr[31:2];
      end
    end
  end

  // Once FETCH is entered the fill always runs to completion, regardless
  // of what the datapath does with imemREN or imemaddr in the meantime.
  always_comb begin
    next_state = state;
    iREN       = 1'b0;
    iaddr      = 32'h0;
    fill_we    = 1'b0;
    miss_start = 1'b0;
    case (state)
      IDLE: begin
        if (imemREN && !ihit) begin
          miss_start = 1'b1;
          next_state = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {fill_addr, 2'b00};
        if (!iwait) begin
          fill_we    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  // Statistics survive flushes; only reset clears them.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (ihit) begin
        hit_q <= sat_inc32(hit_q);
      end
      if (miss_start) begin
        miss_q <= sat_inc32(miss_q);
      end
    end
  end

  assign hitcount  = hit_q;
  assign misscount = miss_q;
`else
  assign hitcount  = 32'h0;
  assign misscount = 32'h0;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed and randomized checks of icache against a
// behavioural model (per-index valid/tag/data arrays plus a synthetic
// backing memory).
module tb_icache;

  localparam int SETS   = 16;
  localparam int IDX_W  = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hitcount;
  logic [31:0] misscount;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  bit          m_valid [SETS];
  logic [31:0] m_addr  [SETS];

  icache #(.SETS(SETS)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .iflush    (iflush),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .hitcount  (hitcount),
    .misscount (misscount)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h40) return 32'hDEAD_BEEF;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[IDX_W+1:2]);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_addr[idx_of(a)][31:IDX_W+2] == a[31:IDX_W+2]);
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    m_valid[idx_of(a)] = 1'b1;
    m_addr[idx_of(a)]  = a;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_counters();
`ifdef ICACHE_STATS_EN
    checkOutput("hitcount", hitcount, 32'(exp_hits));
    checkOutput("misscount", misscount, 32'(exp_miss));
`else
    checkOutput("hitcount", hitcount, 32'h0);
    checkOutput("misscount", misscount, 32'h0);
`endif
  endtask

  // Drive one cycle's inputs at the falling edge, then settle.
  task automatic applyStimulus(input logic req, input logic [31:0] a, input logic wt,
                               input logic [31:0] ld, input logic fl);
    @(negedge CLK);
    imemREN  = req;
    imemaddr = a;
    iwait    = wt;
    iload    = ld;
    iflush   = fl;
    #1;
  endtask

  // A complete fetch of address a, holding the request until it is served.
  task automatic access(input logic [31:0] a, input int waits);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    applyStimulus(1'b1, a, 1'b1, 32'h0, 1'b0);
    check_counters();
    if (model_hit(a)) begin
      checkOutput("hit ihit", ihit, 1'b1);
      checkOutput("hit data", imemload, mem_word(a));
      checkOutput("hit iREN", iREN, 1'b0);
      exp_hits++;
    end else begin
      checkOutput("miss ihit", ihit, 1'b0);
      checkOutput("miss data", imemload, 32'h0);
      exp_miss++;
      for (int w = 0; w < waits; w++) begin
        applyStimulus(1'b1, a, 1'b1, 32'h0, 1'b0);
        checkOutput("wait iREN", iREN, 1'b1);
        checkOutput("wait iaddr", iaddr, wa);
        checkOutput("wait ihit", ihit, 1'b0);
      end
      applyStimulus(1'b1, a, 1'b0, mem_word(a), 1'b0);
      checkOutput("done iREN", iREN, 1'b1);
      checkOutput("done iaddr", iaddr, wa);
      model_fill(a);
      applyStimulus(1'b1, a, 1'b1, 32'h0, 1'b0);
      checkOutput("post-fill ihit", ihit, 1'b1);
      checkOutput("post-fill data", imemload, mem_word(a));
      checkOutput("post-fill iREN", iREN, 1'b0);
      exp_hits++;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    imemREN = 1'b0; imemaddr = 32'h0; iflush = 1'b0; iwait = 1'b1; iload = 32'h0;
    model_flush();
    exp_hits = 0;
    exp_miss = 0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    nRST = 1'b0;
    imemREN = 1'b0; imemaddr = 32'h0; iflush = 1'b0; iwait = 1'b1; iload = 32'h0;
    model_flush();

    // Reset state
    do_reset();
    #1;
    checkOutput("reset ihit", ihit, 1'b0);
    checkOutput("reset imemload", imemload, 32'h0);
    checkOutput("reset iREN", iREN, 1'b0);
    checkOutput("reset iaddr", iaddr, 32'h0);
    check_counters();

    // Cold miss with three wait cycles, then re-access hits
    access(32'h0000_0040, 3);
    access(32'h0000_0040, 0);
    access(32'h0000_0042, 0);

    // Conflict miss on the same index, then the original misses again
    access(32'h0000_0440, 1);
    access(32'h0000_0040, 0);

    // Address change mid-fill: the in-flight fill keeps its address
    applyStimulus(1'b1, 32'h80, 1'b1, 32'h0, 1'b0);
    checkOutput("chg miss", ihit, model_hit(32'h80));
    exp_miss++;
    applyStimulus(1'b1, 32'h84, 1'b1, 32'h0, 1'b0);
    checkOutput("chg iaddr0", iaddr, 32'h80);
    checkOutput("chg ihit0", ihit, 1'b0);
    applyStimulus(1'b1, 32'h84, 1'b1, 32'h0, 1'b0);
    checkOutput("chg iaddr1", iaddr, 32'h80);
    applyStimulus(1'b1, 32'h84, 1'b0, mem_word(32'h80), 1'b0);
    checkOutput("chg iaddr2", iaddr, 32'h80);
    model_fill(32'h80);
    access(32'h84, 2);
    access(32'h80, 0);

    // Flush coinciding with fill completion leaves the frame invalid
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h0, 1'b0);
    checkOutput("fl miss", ihit, 1'b0);
    exp_miss++;
    applyStimulus(1'b1, 32'h100, 1'b0, mem_word(32'h100), 1'b1);
    checkOutput("fl iREN", iREN, 1'b1);
    model_flush();
    applyStimulus(1'b0, 32'h100, 1'b1, 32'h0, 1'b0);
    checkOutput("fl idle iREN", iREN, 1'b0);
    access(32'h100, 0);
    access(32'h80, 1);

    // Flush with a request to a resident line masks the hit and refetches
    applyStimulus(1'b1, 32'h80, 1'b1, 32'h0, 1'b1);
    checkOutput("flreq ihit", ihit, 1'b0);
    exp_miss++;
    model_flush();
    applyStimulus(1'b1, 32'h80, 1'b0, mem_word(32'h80), 1'b0);
    checkOutput("flreq iaddr", iaddr, 32'h80);
    model_fill(32'h80);
    access(32'h80, 0);

    // Randomized accesses over a small address space to provoke conflicts
    for (int n = 0; n < 80; n++) begin
      a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, SETS - 1)), 2'($urandom)};
      if ($urandom_range(0, 15) == 0) begin
        applyStimulus(1'b0, a, 1'b1, 32'h0, 1'b1);
        checkOutput("rnd flush ihit", ihit, 1'b0);
        model_flush();
      end
      access(a, int'($urandom_range(0, 3)));
    end

    // Reset mid-FETCH drops iREN immediately and empties the cache
    applyStimulus(1'b1, 32'h3C0, 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h3C0, 1'b1, 32'h0, 1'b0);
    checkOutput("rst pre iREN", iREN, 1'b1);
    nRST = 1'b0;
    #1;
    checkOutput("rst iREN", iREN, 1'b0);
    checkOutput("rst iaddr", iaddr, 32'h0);
    do_reset();
    #1;
    check_counters();
    access(32'h0000_0040, 0);
    access(32'h0000_0080, 1);
    access(32'h0000_0040, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
